// File: rtl/spi_datapath.sv
// spi_datapath: SPI slave (CPOL=0/CPHA=0) frame decoder.
// Frame = 4-bit command, ADDR_W-bit address, DATA_W-bit data, MSB first,
// over 1/2/4 lanes. Produces register-bus style pulses and serialises
// read data onto miso.
// Optional feature macro: SPI_QUAD_EN (spi_mode 2'b10 selects 4 lanes).
// Without it, spi_mode 2'b10 falls back to single-lane operation.
module spi_datapath #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic [3:0]        mosi,
  input  logic [1:0]        spi_mode,
  input  logic [DATA_W-1:0] rdata,
  output logic              address_ready,
  output logic              data_ready,
  output logic [3:0]        miso,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        status,
  output logic [DATA_W-1:0] wdata
);

  localparam int CMD_W   = 4;
  localparam int TOTAL_W = CMD_W + ADDR_W + DATA_W;
  localparam int SR_W    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = $clog2(TOTAL_W + 5);
  localparam logic [CNT_W-1:0] CMD_END   = CNT_W'(CMD_W);
  localparam logic [CNT_W-1:0] ADDR_END  = CNT_W'(CMD_W + ADDR_W);
  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(TOTAL_W);

  // lanes_q encodes log2 of the lane count
  localparam logic [1:0] LANE_1 = 2'd0;
  localparam logic [1:0] LANE_2 = 2'd1;
  localparam logic [1:0] LANE_4 = 2'd2;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
  logic              sclk_prev_q, sclk_prev_d;
  logic [1:0]        lanes_q, lanes_d, lanes_sel;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_next, step;
  logic [SR_W-1:0]   rx_q, rx_d, rx_shift;
  logic [DATA_W-1:0] tx_q, tx_d, tx_shift, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        status_q, status_d, miso_lanes;
  logic              address_ready_q, address_ready_d;
  logic              data_ready_q, data_ready_d;
  logic              sclk_s, cs_s, sclk_rise, sclk_fall, shift_rx;
  logic [3:0]        mosi_s;
  logic              unused_bits;

  assign sclk_s    = sync_q[SYNC_STAGES-1][5];
  assign cs_s      = sync_q[SYNC_STAGES-1][4];
  assign mosi_s    = sync_q[SYNC_STAGES-1][3:0];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign step      = CNT_W'(1) << lanes_q;
  assign cnt_next  = cnt_q + step;
  assign shift_rx  = sclk_rise && !cs_s &&
                     (state_q == CMD || state_q == ADDR || state_q == DATA);
  // top rx bit always shifts out; upper mosi lanes unused in narrow builds
  assign unused_bits = ^{rx_q[SR_W-1], mosi_s};

  // Synchroniser chain for the asynchronous SPI pins
  always_comb begin
    sync_d[0] = {sclk, cs_n, mosi};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    sclk_prev_d = sclk_s;
  end

  // Lane-mode decode and per-width shift/serialise helpers
  always_comb begin
    lanes_sel  = LANE_1;
    rx_shift   = {rx_q[SR_W-2:0], mosi_s[0]};
    tx_shift   = {tx_q[DATA_W-2:0], 1'b0};
    miso_lanes = {3'b000, tx_q[DATA_W-1]};
    case (spi_mode)
      2'b01:   lanes_sel = LANE_2;
`ifdef SPI_QUAD_EN
      2'b10:   lanes_sel = LANE_4;
`endif
      default: lanes_sel = LANE_1;
    endcase
    case (lanes_q)
      LANE_2: begin
        rx_shift   = {rx_q[SR_W-3:0], mosi_s[1:0]};
        tx_shift   = {tx_q[DATA_W-3:0], 2'b00};
        miso_lanes = {2'b00, tx_q[DATA_W-1 -: 2]};
      end
`ifdef SPI_QUAD_EN
      LANE_4: begin
        rx_shift   = {rx_q[SR_W-5:0], mosi_s[3:0]};
        tx_shift   = {tx_q[DATA_W-5:0], 4'b0000};
        miso_lanes = tx_q[DATA_W-1 -: 4];
      end
`endif
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: field boundaries are multiples of 4 so cnt hits them exactly
  always_comb begin
    state_d = state_q;
    if (cs_s) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: state_d = CMD;
        CMD:  if (shift_rx && cnt_next == CMD_END)   state_d = ADDR;
        ADDR: if (shift_rx && cnt_next == ADDR_END)  state_d = DATA;
        DATA: if (shift_rx && cnt_next == FRAME_END) state_d = DONE;
        default: ;
      endcase
    end
  end

  // FSM outputs / datapath next values
  always_comb begin
    lanes_d         = lanes_q;
    cnt_d           = cnt_q;
    rx_d            = rx_q;
    tx_d            = tx_q;
    addr_d          = addr_q;
    status_d        = status_q;
    wdata_d         = wdata_q;
    address_ready_d = 1'b0;
    data_ready_d    = 1'b0;
    if (cs_s) begin
      cnt_d = '0;
    end else if (state_q == IDLE) begin
      cnt_d   = '0;
      lanes_d = lanes_sel;
    end else if (shift_rx) begin
      rx_d  = rx_shift;
      cnt_d = cnt_next;
      if (cnt_next == CMD_END) status_d = rx_shift[3:0];
      if (cnt_next == ADDR_END) begin
        addr_d          = rx_shift[ADDR_W-1:0];
        address_ready_d = 1'b1;
        if (!status_q[3]) tx_d = rdata;
      end
      if (cnt_next == FRAME_END && status_q[3]) begin
        wdata_d      = rx_shift[DATA_W-1:0];
        data_ready_d = 1'b1;
      end
    end else if (sclk_fall && state_q == DATA && cnt_q != ADDR_END) begin
      // The falling edge right after the address edge is skipped so the
      // master's first data-phase rising edge samples the top chunk.
      tx_d = tx_shift;
    end
  end

  // Datapath and synchroniser registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q          <= {SYNC_STAGES{6'b01_0000}};
      sclk_prev_q     <= 1'b0;
      lanes_q         <= LANE_1;
      cnt_q           <= '0;
      rx_q            <= '0;
      tx_q            <= '0;
      addr_q          <= '0;
      status_q        <= '0;
      wdata_q         <= '0;
      address_ready_q <= 1'b0;
      data_ready_q    <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      sclk_prev_q     <= sclk_prev_d;
      lanes_q         <= lanes_d;
      cnt_q           <= cnt_d;
      rx_q            <= rx_d;
      tx_q            <= tx_d;
      addr_q          <= addr_d;
      status_q        <= status_d;
      wdata_q         <= wdata_d;
      address_ready_q <= address_ready_d;
      data_ready_q    <= data_ready_d;
    end
  end

  assign address_ready = address_ready_q;
  assign data_ready    = data_ready_q;
  assign addr          = addr_q;
  assign status        = status_q;
  assign wdata         = wdata_q;
  assign miso          = (state_q == DATA && !status_q[3]) ? miso_lanes : 4'b0000;

endmodule

// File: tb/tb_spi_datapath.sv
// Bench for spi_datapath: directed frames from the test plan plus random
// frames, checked against a frame-level model of the SPI protocol.
module tb_spi_datapath;
  localparam int HALF = 5;  // sclk half period in clk cycles

  logic        clk = 1'b0, reset_n = 1'b0, sclk = 1'b0, cs_n = 1'b1;
  logic [3:0]  mosi = 4'h0;
  logic [1:0]  spi_mode = 2'b00;
  logic [15:0] rdata = 16'h0;
  logic        address_ready, data_ready;
  logic [3:0]  miso, status;
  logic [19:0] addr;
  logic [15:0] wdata;

  spi_datapath dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .spi_mode(spi_mode), .rdata(rdata), .address_ready(address_ready),
    .data_ready(data_ready), .miso(miso), .addr(addr), .status(status),
    .wdata(wdata)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int ar_cnt = 0, dr_cnt = 0;
  logic [19:0] m_addr = '0;
  logic [3:0]  m_status = '0;
  logic [15:0] m_wdata = '0;

  // count high cycles of each pulse; a proper pulse contributes exactly one
  always @(posedge clk) begin
    if (address_ready) ar_cnt <= ar_cnt + 1;
    if (data_ready)    dr_cnt <= dr_cnt + 1;
  end

  function automatic int width_of(input logic [1:0] m);
    case (m)
      2'b01:   return 2;
`ifdef SPI_QUAD_EN
      2'b10:   return 4;
`endif
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame as the SPI master; nbits < 40 aborts early.
  task automatic frame(input logic [3:0] cmd, input logic [19:0] a, input logic [15:0] d,
                       input logic [1:0] mode, input logic [15:0] rd, input int nbits);
    int w, nedge, ar0, dr0, k;
    logic [39:0] bits;
    logic [3:0]  mask, exp_miso;
    w     = width_of(mode);
    nedge = nbits / w;
    bits  = {cmd, a, d};
    mask  = 4'((1 << w) - 1);
    spi_mode = mode;
    rdata = rd;
    ar0 = ar_cnt;
    dr0 = dr_cnt;
    @(negedge clk) cs_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_mode = 2'($urandom);  // must be ignored once the frame has started
    for (int e = 0; e < nedge; e++) begin
      mosi = (4'($urandom) & ~mask) | (4'(bits >> (40 - w * (e + 1))) & mask);
      repeat (HALF) @(negedge clk);
      exp_miso = 4'h0;
      if (!cmd[3] && e >= 24 / w) begin
        k = e - 24 / w;
        exp_miso = 4'(rd >> (16 - w * (k + 1))) & mask;
      end
      chk("miso", {28'h0, miso}, {28'h0, exp_miso});
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    if (nbits >= 4)               m_status = cmd;
    if (nbits >= 24)              m_addr   = a;
    if (nbits >= 40 && cmd[3])    m_wdata  = d;
    chk("address_ready_pulses", 32'(ar_cnt - ar0), (nbits >= 24) ? 32'd1 : 32'd0);
    chk("data_ready_pulses", 32'(dr_cnt - dr0), (nbits >= 40 && cmd[3]) ? 32'd1 : 32'd0);
    chk("addr", {12'h0, addr}, {12'h0, m_addr});
    chk("status", {28'h0, status}, {28'h0, m_status});
    chk("wdata", {16'h0, wdata}, {16'h0, m_wdata});
    chk("miso_idle", {28'h0, miso}, 32'h0);
  endtask

  initial begin
    // reset with sclk toggling
    cs_n = 1'b0;
    mosi = 4'hF;
    for (int i = 0; i < 10; i++) #5 sclk = ~sclk;
    @(negedge clk);
    chk("rst_addr", {12'h0, addr}, 32'h0);
    chk("rst_status", {28'h0, status}, 32'h0);
    chk("rst_wdata", {16'h0, wdata}, 32'h0);
    chk("rst_miso", {28'h0, miso}, 32'h0);
    chk("rst_pulses", 32'(ar_cnt + dr_cnt), 32'h0);
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 4'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    frame(4'h8, 20'h12345, 16'hBEEF, 2'b01, 16'h0000, 40);   // dual write
    frame(4'h0, 20'h00ABC, 16'h5555, 2'b01, 16'hC69A, 40);   // dual read
    frame(4'h8, 20'hFFFFF, 16'h0001, 2'b00, 16'h0000, 40);   // single write
    frame(4'h8, 20'h3C3C3, 16'h7777, 2'b00, 16'h0000, 14);   // abort after 10 addr bits
    frame(4'h9, 20'h5A5A5, 16'h1357, 2'b01, 16'h0000, 40);   // recovery
    frame(4'h0, 20'h00042, 16'h0000, 2'b10, 16'h1234, 40);   // quad (or single) read
    frame(4'h1, 20'hABCDE, 16'h0000, 2'b11, 16'hF00D, 40);   // mode 11 = single read

    for (int n = 0; n < 8; n++)
      frame(4'($urandom), 20'($urandom), 16'($urandom), 2'($urandom),
            16'($urandom), 40);

    // reset in the middle of a frame
    @(negedge clk) cs_n = 1'b0;
    mosi = 4'hF;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      repeat (HALF) @(negedge clk);
      sclk = ~sclk;
    end
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_addr", {12'h0, addr}, 32'h0);
    chk("midrst_status", {28'h0, status}, 32'h0);
    chk("midrst_wdata", {16'h0, wdata}, 32'h0);
    chk("midrst_miso", {28'h0, miso}, 32'h0);
    chk("midrst_pulses", {30'h0, data_ready, address_ready}, 32'h0);
    cs_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_addr = '0;
    m_status = '0;
    m_wdata = '0;
    repeat (5) @(negedge clk);
    frame(4'hA, 20'h0F0F0, 16'hA5A5, 2'b01, 16'h0000, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_datapath.md
Name: spi_datapath

Overview:
SPI slave data path that converts a serial SPI frame into a parallel register-bus request. Frame: 4-bit command, then 20-bit address, then 16-bit data, all MSB first, over 1, 2 or 4 lanes. Sits between the external SPI pins and the register/crypto core. Captures write data and serialises read data (rdata) back onto miso.

Parameters:
ADDR_W, 20, address field width (multiple of 4)
DATA_W, 16, data field width (multiple of 4)
SYNC_STAGES, 2, synchroniser depth for sclk, cs_n and mosi into clk domain

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock, CPOL=0/CPHA=0, asynchronous to clk
cs_n  input  1  SPI chip select, active low
mosi  input  4  SPI data in lanes
spi_mode  input  2  lane mode: 00 single (lane 0), 01 dual (lanes 1:0), 10 quad (lanes 3:0), 11 treated as single
rdata  input  16  read data from core, sampled at address completion
address_ready  output  1  one-clk pulse when addr is valid
data_ready  output  1  one-clk pulse when wdata is valid (write frames only)
miso  output  4  SPI data out lanes
addr  output  20  captured address
status  output  4  captured command nibble; status[3]=1 write, 0 read
wdata  output  16  captured write data

Behaviour:
- Reset: all outputs 0, bit counter 0, state IDLE.
- sclk, cs_n and mosi pass through SYNC_STAGES flops. Rising/falling edges of sclk are detected from the last two synchronised samples. Requires clk >= 4x sclk.
- Lane width W = 1/2/4 per spi_mode, latched at cs_n falling edge. spi_mode changes mid-frame are ignored.
- States: IDLE -> CMD on synchronised cs_n low; CMD -> ADDR after 4 bits; ADDR -> DATA after 24 total bits; DATA -> DONE after 40 total bits. Any state -> IDLE when synchronised cs_n is high.
- Each synchronised sclk rising edge in CMD, ADDR or DATA shifts W bits in (mosi[W-1:0], highest lane = most significant) and advances the bit counter by W.
- status updates when the command completes and holds until the next command completes.
- Address completion: addr updated, address_ready pulses for exactly 1 clk in the cycle after the detecting edge.
- Read (status[3]=0):
  - rdata is loaded into the tx shift register in the same cycle as address_ready.
  - The top W bits drive miso[W-1:0] immediately.
  - Each sclk falling edge in DATA shifts W bits.
  - No data_ready pulse. wdata is unchanged.
- Write (status[3]=1): after 40 bits, wdata is updated and data_ready pulses for 1 clk.
- miso is 0 outside the read DATA phase, and unused lanes are 0.
- DONE: extra sclk edges are ignored until cs_n rises.
- cs_n rising mid-frame: the partial frame is discarded, no pulses, and addr/wdata/status hold their last values. The counter clears, and the next cs_n fall starts a fresh frame.
- Reset mid-frame: immediate return to reset values.

Optional Feature:
Macro SPI_QUAD_EN.
- Defined: spi_mode 10 selects quad, 4 bits per edge.
- Undefined: spi_mode 10 is treated as single and mosi[3:2] are ignored. miso[3:2] are tied to 0 and the quad shift logic is not generated.

Test Plan:
- Reset: hold reset_n=0 for 50 ns with sclk toggling -> all outputs 0, no pulses.
- Dual write: clk 100 MHz, sclk 25 MHz, spi_mode=01, send cmd 4'h8, addr 20'h12345, data 16'hBEEF over 20 sclk cycles -> status=8, then address_ready pulse with addr=12345, then data_ready pulse with wdata=BEEF.
- Dual read: spi_mode=01, cmd 4'h0, addr 20'h00ABC, rdata=16'hC69A -> address_ready pulse. miso[1:0] yields C69A MSB-first over the next 8 falling edges, and data_ready stays 0.
- Single write: spi_mode=00, 40 sclk cycles, cmd 8, addr FFFFF, data 0001 -> addr=FFFFF, wdata=0001, miso=0 throughout.
- Abort: cs_n rises after 10 address bits -> no address_ready. The next complete frame is captured correctly.
- Quad read (SPI_QUAD_EN defined): spi_mode=10, 10 sclk cycles, rdata=16'h1234 -> miso nibbles 1,2,3,4. Same test with SPI_QUAD_EN undefined -> behaves as single.
